// File: rtl/display_scan.sv
// display_scan: 8-digit multiplexed seven-segment driver for the timer, with edit-position highlight.
// Define DISPLAY_BLINK_EN to blink the edited digit and flash the display on done; otherwise dp marks them.
module display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] bcd_i,
    input  logic [2:0]  curr_digit,
    input  logic        edit,
    input  logic        done,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    logic [RW-1:0] rcnt;
    logic [2:0]    k;
    logic [35:0]   snap;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic [7:0]    an_n;
    logic          wrap, sel, sep, dp_n;
    assign wrap = rcnt == RW'(REFRESH_DIV - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            k    <= '0;
            snap <= '0;
        end else begin
            rcnt <= wrap ? '0 : rcnt + 1'b1;
            if (wrap) k <= k + 3'd1;
            if (wrap && k == 3'd7) snap <= bcd_i;
        end
    end
    // Position k shows the nibble one above it, so ms1 never reaches the display.
    assign nib = snap[{k, 2'b00} + 6'd4 +: 4];
    always_comb begin
        glyph = 7'b0111111;
        case (nib)
            4'd0: glyph = 7'b1000000;
            4'd1: glyph = 7'b1111001;
            4'd2: glyph = 7'b0100100;
            4'd3: glyph = 7'b0110000;
            4'd4: glyph = 7'b0011001;
            4'd5: glyph = 7'b0010010;
            4'd6: glyph = 7'b0000010;
            4'd7: glyph = 7'b1111000;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    end
    assign sel = edit && curr_digit <= 3'd5 && k == 3'd7 - curr_digit;
    assign sep = k == 3'd6 || k == 3'd4 || k == 3'd2;
`ifdef DISPLAY_BLINK_EN
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] bcnt;
    logic          phase;
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
            if (bcnt == BW'(BLINK_DIV - 1)) phase <= ~phase;
        end
    end
    assign an_n = (done && phase) ? 8'hFF : ~(8'd1 << k) | ({7'd0, sel && phase} << k);
    assign dp_n = !sep;
`else
    assign an_n = ~(8'd1 << k);
    assign dp_n = !(sep || sel || done);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_n;
            seg <= glyph;
            dp  <= dp_n;
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed bench for display_scan with REFRESH_DIV=4, BLINK_DIV=8.
// Works in both builds; DISPLAY_BLINK_EN selects the expected blanking/dp behaviour.
module tb_display_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] bcd_i = '0;
    logic [2:0]  curr_digit = '0;
    logic        edit = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int vectors = 0;
    int errs = 0;
    int n = 0;
    always #5 clk = ~clk;
    display_scan #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst(rst), .bcd_i(bcd_i), .curr_digit(curr_digit),
        .edit(edit), .done(done), .an(an), .seg(seg), .dp(dp)
    );
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask
    // Output after posedge n shows slot k = ((n-1)/4) mod 8.
    function automatic int kk();
        return ((n - 1) / 4) % 8;
    endfunction
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction
    task automatic step();
        int k;
        logic s;
        logic [7:0] ea;
        @(posedge clk);
        @(negedge clk);
        n++;
        k = kk();
        s = edit && curr_digit <= 3'd5 && k == 7 - int'(curr_digit);
        ea = ~(8'd1 << k);
`ifdef DISPLAY_BLINK_EN
        if (((n - 1) / 8) % 2 == 1) begin
            if (done) ea = 8'hFF;
            else if (s) ea[k] = 1'b1;
        end
        chk($sformatf("an n=%0d", n), an, ea);
        chk($sformatf("dp n=%0d", n), {7'd0, dp}, {7'd0, !(k == 6 || k == 4 || k == 2)});
`else
        chk($sformatf("an n=%0d", n), an, ea);
        chk($sformatf("dp n=%0d", n), {7'd0, dp}, {7'd0, !(k == 6 || k == 4 || k == 2 || s || done)});
`endif
    endtask
    task automatic seg_at(input int j, input int d);
        int b = 0;
        do begin
            step();
            b++;
        end while (kk() != j && b < 40);
        chk($sformatf("seg k=%0d n=%0d", j, n), {1'b0, seg}, {1'b0, glyph(d)});
    endtask
    initial begin
        bcd_i = 36'h123456780;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst an", an, 8'hFF);
        chk("rst seg", {1'b0, seg}, 8'h7F);
        chk("rst dp", {7'd0, dp}, 8'h01);
        rst = 1'b0;
        n = 0;
        seg_at(0, 0);
        repeat (31) step();
        for (int j = 0; j < 8; j++) seg_at(j, 8 - j);
        bcd_i = 36'h111111111;
        seg_at(0, 1);
        seg_at(3, 1);
        bcd_i = 36'hB22222222;
        seg_at(4, 1);
        seg_at(7, 1);
        seg_at(0, 2);
        seg_at(3, 2);
        seg_at(6, 2);
        seg_at(7, 11);
        edit = 1'b1;
        curr_digit = 3'd2;
        repeat (32) step();
        curr_digit = 3'd6;
        repeat (32) step();
        curr_digit = 3'd7;
        repeat (8) step();
        curr_digit = 3'd2;
        edit = 1'b0;
        repeat (16) step();
        done = 1'b1;
        repeat (32) step();
        done = 1'b0;
        edit = 1'b1;
        curr_digit = 3'd0;
        repeat (32) step();
        edit = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst an", an, 8'hFF);
        chk("midrst seg", {1'b0, seg}, 8'h7F);
        chk("midrst dp", {7'd0, dp}, 8'h01);
        rst = 1'b0;
        n = 0;
        step();
        chk("post-rst seg", {1'b0, seg}, {1'b0, glyph(0)});
        repeat (8) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
